// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the core's
// load/store port. A request is accepted in IDLE, held for LATENCY extra
// cycles in WAIT, committed against an internal word array (byte strobes
// on stores, old word returned on every access) and presented in RESP until
// the core takes it.
// Optional build macro: DMEM_ERR_EN adds the rsp_err port and an address
// range check; without it out-of-range addresses wrap modulo the depth.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  commit;
    logic                  mem_we;
    logic                  unused_bits;

    // Word index relative to the base; the subtraction wraps as 32-bit unsigned.
    assign off = addr_q - BASE_ADDR;
    assign idx = off[DEPTH_LOG2+1:2];

`ifdef DMEM_ERR_EN
    // Any offset bit above the array span means the address is out of range
    // (addresses below the base wrap to huge offsets and are caught too).
    assign in_range    = ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign unused_bits = ^off[1:0];
`else
    assign in_range    = 1'b1;
    assign unused_bits = ^{off[31:DEPTH_LOG2+2], off[1:0], err_q, err_d};
`endif

    // The access commits on the edge that leaves WAIT; a reset edge never commits.
    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we = commit && wen_q && in_range && rst;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
`ifdef DMEM_ERR_EN
    assign rsp_err   = err_q;
`endif

    // Next-state and datapath next values for the request/response FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = in_range ? mem[idx] : 32'd0;
                    err_d   = !in_range;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, captured request and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            rdata_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Byte-strobed store into the array at the commit edge; the array is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized load/store traffic against a
// word-array reference model of dmem_responder (LATENCY=2, DEPTH_LOG2=10).
module tb_dmem_responder;

    localparam int          LAT  = 2;
    localparam int          DL2  = 10;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wmask = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
`ifdef DMEM_ERR_EN
    logic        rsp_err;
    localparam bit ERR_MODE = 1'b1;
`else
    localparam bit ERR_MODE = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference memory: word index -> contents, only for words with known value.
    logic [31:0] mdl [int unsigned];

    logic        p_wen;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wmask;
    logic [31:0] last_rdata;
    int          last_wait;
    logic [31:0] pool [8];

    dmem_responder #(
        .DEPTH_LOG2(DL2),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata)
`ifdef DMEM_ERR_EN
        ,
        .rsp_err  (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (o / 32'd4) % 32'(1 << DL2);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned la, lb, span;
        la   = 64'(a);
        lb   = 64'(BASE);
        span = 64'(4) << DL2;
        return (la >= lb) && (la < lb + span);
    endfunction

    // Present a request, wait (bounded) for req_ready, return just after the accept edge.
    task automatic accept_req(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] m);
        req_wen   = wen;
        req_addr  = a;
        req_wdata = wd;
        req_wmask = m;
        req_valid = 1'b1;
        last_wait = 0;
        while (!req_ready && last_wait < 64) begin
            tick();
            last_wait++;
        end
        tick();
        req_valid = 1'b0;
        p_wen   = wen;
        p_addr  = a;
        p_wdata = wd;
        p_wmask = m;
    endtask

    // Predict the pending access, wait for the response, stall, handshake.
    task automatic finish_rsp(input int stall, input string tag);
        logic        exp_e;
        logic        known;
        logic [31:0] exp_d, held, bm;
        int unsigned k;
        int          lat;
        exp_e = ERR_MODE && !in_rng(p_addr);
        k     = widx(p_addr);
        known = exp_e || mdl.exists(k);
        exp_d = exp_e ? 32'd0 : (mdl.exists(k) ? mdl[k] : 32'd0);
        if (!exp_e && p_wen) begin
            bm = {{8{p_wmask[3]}}, {8{p_wmask[2]}}, {8{p_wmask[1]}}, {8{p_wmask[0]}}};
            if (mdl.exists(k)) mdl[k] = (mdl[k] & ~bm) | (p_wdata & bm);
            else if (p_wmask == 4'hF) mdl[k] = p_wdata;
        end
        lat = 0;
        while (!rsp_valid && lat < 64) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(LAT + 1));
        if (known) chk({tag, " rdata"}, rsp_rdata, exp_d);
`ifdef DMEM_ERR_EN
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_e));
`endif
        held = rsp_rdata;
        repeat (stall) begin
            tick();
            chk({tag, " stall valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " stall rdata"}, rsp_rdata, held);
            chk({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " post valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " post req_ready"}, 32'(req_ready), 32'd1);
        last_rdata = held;
    endtask

    initial begin
        // Reset state
        #3;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full store then load with latency check
        accept_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        finish_rsp(0, "st1");
        accept_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        finish_rsp(0, "ld1");
        chk("ld1 value", last_rdata, 32'hDEAD_BEEF);

        // Byte strobe on lane 1
        accept_req(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0010);
        finish_rsp(0, "st2");
        chk("st2 old value", last_rdata, 32'hDEAD_BEEF);
        accept_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        finish_rsp(0, "ld2");
        chk("ld2 merged", last_rdata, 32'hDEAD_33EF);

        // Backpressure with a second request held pending
        accept_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0014;
        req_wdata = 32'h0BAD_F00D;
        req_wmask = 4'hF;
        req_valid = 1'b1;
        finish_rsp(5, "bp1");
        chk("bp1 value", last_rdata, 32'hDEAD_33EF);
        accept_req(1'b1, 32'h8000_0014, 32'h0BAD_F00D, 4'hF);
        chk("bp2 accept wait", 32'(last_wait), 32'd0);
        chk("bp2 busy", 32'(req_ready), 32'd0);
        finish_rsp(0, "bp2");

        // Reset during WAIT drops the store
        accept_req(1'b1, 32'h8000_0020, 32'h0, 4'hF);
        finish_rsp(0, "clr");
        accept_req(1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF);
        tick();
        #1 rst_n = 1'b0;
        #1 chk("rstwait rsp_valid", 32'(rsp_valid), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("rstwait req_ready", 32'(req_ready), 32'd1);
        chk("rstwait rsp_valid2", 32'(rsp_valid), 32'd0);
        accept_req(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        finish_rsp(0, "rstld");
        chk("rstld value", last_rdata, 32'd0);

`ifndef DMEM_ERR_EN
        // Wrap modulo array depth
        accept_req(1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF);
        finish_rsp(0, "wrap st");
        accept_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        finish_rsp(0, "wrap ld");
        chk("wrap value", last_rdata, 32'h1234_5678);
`else
        // Out-of-range store is rejected and leaves memory untouched
        accept_req(1'b1, 32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF);
        finish_rsp(0, "err init");
        accept_req(1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF);
        finish_rsp(0, "err st");
        chk("err st err", 32'(rsp_err), 32'd1);
        chk("err st rdata", last_rdata, 32'd0);
        accept_req(1'b0, 32'h8000_0FFC, 32'h0, 4'h0);
        finish_rsp(0, "err ld");
        chk("err ld err", 32'(rsp_err), 32'd0);
        chk("err ld value", last_rdata, 32'hA5A5_5A5A);
`endif

        // Randomized traffic over a small address pool, including wrap/out-of-range aliases
        for (int i = 0; i < 6; i++) pool[i] = BASE + 32'(4 * (i + 8));
        pool[6] = BASE + 32'h0000_1000 + 32'h24;
        pool[7] = BASE - 32'd4;
        for (int i = 0; i < 8; i++) begin
            accept_req(1'b1, pool[i], $urandom, 4'hF);
            finish_rsp(0, "rnd init");
        end
        for (int i = 0; i < 40; i++) begin
            accept_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
                       4'($urandom_range(0, 15)));
            finish_rsp(int'($urandom_range(0, 3)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
